// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM controller.
package mem_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    // Request address bit that selects extram over baseram
    localparam int unsigned BANK_BIT = 20;

    // Width of the strobe-duration counter
    localparam int unsigned CNT_W = 8;

    // Level of an inactive active-low strobe
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_ctrl.sv
// Single-word read/write responder driving two async SRAM banks.
module sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = BANK_BIT,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned WRITE_CYCLES = 1
) (
    input  logic              clk_mem,
    input  logic              rst,
    input  logic [CNT_W-1:0]  ram_read_wait,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W:0]   req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] baseram_addr,
    output logic [ADDR_W-1:0] extram_addr,
    inout  wire  [DATA_W-1:0] baseram_data,
    inout  wire  [DATA_W-1:0] extram_data,
    output logic              baseram_ce,
    output logic              baseram_oe,
    output logic              baseram_we,
    output logic              extram_ce,
    output logic              extram_oe,
    output logic              extram_we
);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                bank, bank_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic [DATA_W-1:0]   rdata_n;
    logic                busy_n, ack_n;
    logic                ce_on, oe_on, we_on, drv_on;
    logic                base_drv, ext_drv;

    // Bank buses are driven only while a write owns them
    assign baseram_data = base_drv ? wdata_q : {DATA_W{1'bz}};
    assign extram_data  = ext_drv  ? wdata_q : {DATA_W{1'bz}};

    // Next-state, counter and strobe-intent decode
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bank_n  = bank;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        rdata_n = rdata;
        busy_n  = busy;
        ack_n   = 1'b0;
        ce_on   = 1'b0;
        oe_on   = 1'b0;
        we_on   = 1'b0;
        drv_on  = 1'b0;
        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (req) begin
                    bank_n  = req_addr[ADDR_W];
                    addr_n  = req_addr[ADDR_W-1:0];
                    wdata_n = req_wdata;
                    busy_n  = 1'b1;
                    ce_on   = 1'b1;
                    if (req_we) begin
                        drv_on  = 1'b1;
                        state_n = WR_SETUP;
                    end else begin
                        oe_on   = 1'b1;
                        cnt_n   = ram_read_wait;
                        state_n = RD;
                    end
                end
            end
            RD: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                    ce_on = 1'b1;
                    oe_on = 1'b1;
                end else begin
                    rdata_n = bank ? extram_data : baseram_data;
                    ack_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            WR_SETUP: begin
                ce_on   = 1'b1;
                drv_on  = 1'b1;
                we_on   = 1'b1;
                cnt_n   = CNT_W'(WRITE_CYCLES - 1);
                state_n = WR_PULSE;
            end
            WR_PULSE: begin
                ce_on  = 1'b1;
                drv_on = 1'b1;
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                    we_on = 1'b1;
                end else begin
                    state_n = WR_HOLD;
                end
            end
            WR_HOLD: begin
                ack_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and per-bank pin registers
    always_ff @(posedge clk_mem) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bank         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata        <= '0;
            busy         <= 1'b0;
            ack          <= 1'b0;
            baseram_addr <= '0;
            extram_addr  <= '0;
            baseram_ce   <= STROBE_OFF;
            baseram_oe   <= STROBE_OFF;
            baseram_we   <= STROBE_OFF;
            extram_ce    <= STROBE_OFF;
            extram_oe    <= STROBE_OFF;
            extram_we    <= STROBE_OFF;
            base_drv     <= 1'b0;
            ext_drv      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bank         <= bank_n;
            addr_q       <= addr_n;
            wdata_q      <= wdata_n;
            rdata        <= rdata_n;
            busy         <= busy_n;
            ack          <= ack_n;
            baseram_addr <= addr_n;
            extram_addr  <= addr_n;
            baseram_ce   <= (ce_on & ~bank_n) ? ~STROBE_OFF : STROBE_OFF;
            baseram_oe   <= (oe_on & ~bank_n) ? ~STROBE_OFF : STROBE_OFF;
            baseram_we   <= (we_on & ~bank_n) ? ~STROBE_OFF : STROBE_OFF;
            extram_ce    <= (ce_on &  bank_n) ? ~STROBE_OFF : STROBE_OFF;
            extram_oe    <= (oe_on &  bank_n) ? ~STROBE_OFF : STROBE_OFF;
            extram_we    <= (we_on &  bank_n) ? ~STROBE_OFF : STROBE_OFF;
            base_drv     <= drv_on & ~bank_n;
            ext_drv      <= drv_on &  bank_n;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a two-bank behavioural SRAM model.
module tb_sram_ctrl;

    localparam int unsigned WC = 1;

    logic        clk_mem = 1'b0;
    logic        rst;
    logic [7:0]  ram_read_wait;
    logic        req;
    logic        req_we;
    logic [20:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        ack;
    logic [31:0] rdata;
    logic [19:0] baseram_addr;
    logic [19:0] extram_addr;
    wire  [31:0] baseram_data;
    wire  [31:0] extram_data;
    logic        baseram_ce, baseram_oe, baseram_we;
    logic        extram_ce, extram_oe, extram_we;

    sram_ctrl #(.ADDR_W(20), .DATA_W(32), .WRITE_CYCLES(WC)) dut (
        .clk_mem       (clk_mem),
        .rst           (rst),
        .ram_read_wait (ram_read_wait),
        .req           (req),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .busy          (busy),
        .ack           (ack),
        .rdata         (rdata),
        .baseram_addr  (baseram_addr),
        .extram_addr   (extram_addr),
        .baseram_data  (baseram_data),
        .extram_data   (extram_data),
        .baseram_ce    (baseram_ce),
        .baseram_oe    (baseram_oe),
        .baseram_we    (baseram_we),
        .extram_ce     (extram_ce),
        .extram_oe     (extram_oe),
        .extram_we     (extram_we)
    );

    always #5 clk_mem = ~clk_mem;

    // SRAM model: 256 words per bank indexed by the low address byte
    logic [31:0] base_mem [0:255];
    logic [31:0] ext_mem  [0:255];

    initial begin
        for (int i = 0; i < 256; i++) begin
            base_mem[i] = 32'hB000_0000 | 32'(i);
            ext_mem[i]  = 32'hE000_0000 | 32'(i);
        end
        base_mem[8'h10] = 32'hDEAD_BEEF;
    end

    assign baseram_data = (!baseram_ce && !baseram_oe && baseram_we) ? base_mem[baseram_addr[7:0]] : 32'hz;
    assign extram_data  = (!extram_ce  && !extram_oe  && extram_we)  ? ext_mem[extram_addr[7:0]]   : 32'hz;

    always @(posedge clk_mem) begin
        if (!baseram_ce && !baseram_we) base_mem[baseram_addr[7:0]] <= baseram_data;
        if (!extram_ce  && !extram_we)  ext_mem[extram_addr[7:0]]   <= extram_data;
    end

    typedef struct {
        bit          we;
        logic [31:0] rd;
        logic [31:0] wd;
        int unsigned cyc;
        int unsigned width;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    int unsigned cyc = 0;
    int unsigned tests = 0;
    int unsigned errors = 0;
    int unsigned oe_run = 0;
    int unsigned we_run = 0;
    int unsigned ext_low = 0;
    int unsigned conflicts = 0;
    logic [31:0] last_rd = 32'h0;

    always @(posedge clk_mem) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: strobe widths, write-data stability, bus contention and ack scoreboard
    always @(negedge clk_mem) begin
        if (rst) begin
            oe_run = 0;
            we_run = 0;
        end else begin
            if (!baseram_oe || !extram_oe) oe_run++;
            if (!baseram_we || !extram_we) we_run++;
            if (!extram_ce) ext_low++;
            if ((!baseram_oe && dut.base_drv) || (!extram_oe && dut.ext_drv)) conflicts++;
            if (sb.size() > 0 && sb[0].we) begin
                if (!baseram_ce && baseram_oe) check("wr_bus_base", baseram_data, sb[0].wd);
                if (!extram_ce && extram_oe)   check("wr_bus_ext", extram_data, sb[0].wd);
            end
            if (ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_cycle", cyc, e.cyc);
                    check("rdata", rdata, e.rd);
                    check(e.we ? "we_width" : "oe_width", e.we ? we_run : oe_run, e.width);
                end
                oe_run = 0;
                we_run = 0;
            end
        end
    end

    // Drive one request for a single cycle; expected ack is lat edges after accept
    task automatic issue(input bit we, input logic [20:0] a, input logic [31:0] d,
                         input logic [7:0] w, input int unsigned lat, input logic [31:0] exp_rd,
                         input int unsigned width);
        exp_t x;
        req = 1'b1; req_we = we; req_addr = a; req_wdata = d; ram_read_wait = w;
        x.we = we; x.rd = exp_rd; x.wd = d; x.cyc = cyc + 1 + lat; x.width = width;
        sb.push_back(x);
        if (!we) last_rd = exp_rd;
        @(negedge clk_mem);
        req = 1'b0; req_we = 1'b0; req_addr = 21'h0; req_wdata = 32'h0;
    endtask

    task automatic rd(input logic [20:0] a, input logic [7:0] w, input logic [31:0] exp_rd);
        issue(1'b0, a, 32'h0, w, 32'(w) + 1, exp_rd, 32'(w) + 1);
    endtask

    task automatic wr(input logic [20:0] a, input logic [31:0] d);
        issue(1'b1, a, d, 8'd0, WC + 2, last_rd, WC);
    endtask

    // Stop at the negedge that shows ack, bounded
    task automatic wait_ack();
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (ack) got = 1'b1;
            else @(negedge clk_mem);
        end
        if (!got) check("ack_timeout", 0, 1);
    endtask

    task automatic check_idle_pins(input string name);
        check({name, "_strobes"}, {baseram_ce, baseram_oe, baseram_we, extram_ce, extram_oe, extram_we}, 6'b111111);
        check({name, "_busy_ack"}, {busy, ack}, 2'b00);
        check({name, "_drv"}, {dut.base_drv, dut.ext_drv}, 2'b00);
    endtask

    initial begin
        int unsigned ext0;
        rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = 21'h0; req_wdata = 32'h0; ram_read_wait = 8'd0;
        repeat (2) @(negedge clk_mem);
        check_idle_pins("reset");
        check("reset_rdata", rdata, 32'h0);
        check("reset_addr", {baseram_addr, extram_addr}, 40'h0);
        rst = 1'b0;
        @(negedge clk_mem);

        // Base read, zero wait
        ext0 = ext_low;
        rd(21'h000010, 8'd0, 32'hDEAD_BEEF);
        wait_ack();
        check("ext_untouched", ext_low - ext0, 0);
        @(negedge clk_mem);

        // Ext write then read-back
        wr(21'h112345, 32'hA5A5_5A5A);
        check("busy_during_write", busy, 1'b1);
        wait_ack();
        @(negedge clk_mem);
        rd(21'h112345, 8'd0, 32'hA5A5_5A5A);
        wait_ack();
        @(negedge clk_mem);

        // Wait-state read with mid-read change, then maximum wait
        rd(21'h000020, 8'd3, 32'hB000_0020);
        ram_read_wait = 8'd0;
        wait_ack();
        @(negedge clk_mem);
        rd(21'h000021, 8'd255, 32'hB000_0021);
        wait_ack();
        @(negedge clk_mem);

        // Request while busy is dropped; request in ack cycle is taken next edge
        rd(21'h000030, 8'd2, 32'hB000_0030);
        req = 1'b1; req_we = 1'b1; req_addr = 21'h000055; req_wdata = 32'h1111_1111;
        @(negedge clk_mem);
        req = 1'b0; req_we = 1'b0;
        wait_ack();
        rd(21'h000010, 8'd0, 32'hDEAD_BEEF);
        wait_ack();
        @(negedge clk_mem);
        check("busy_drop_ignored", base_mem[8'h55], 32'hB000_0055);

        // Read immediately followed by write to the same bank
        rd(21'h000040, 8'd0, 32'hB000_0040);
        wait_ack();
        wr(21'h000040, 32'h1234_5678);
        wait_ack();
        @(negedge clk_mem);
        rd(21'h000040, 8'd1, 32'h1234_5678);
        wait_ack();
        @(negedge clk_mem);

        // Reset during write pulse
        wr(21'h112399, 32'hCAFE_F00D);
        @(negedge clk_mem);
        rst = 1'b1;
        @(negedge clk_mem);
        check_idle_pins("rst_wr");
        check("rst_wr_rdata", rdata, 32'h0);
        rst = 1'b0;
        sb.delete();
        last_rd = 32'h0;
        @(negedge clk_mem);

        // Reset during read
        rd(21'h000050, 8'd10, 32'hB000_0050);
        repeat (3) @(negedge clk_mem);
        rst = 1'b1;
        @(negedge clk_mem);
        check_idle_pins("rst_rd");
        rst = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk_mem);
        check("no_ack_after_abort", ack, 1'b0);

        // Normal read after abort
        rd(21'h000010, 8'd1, 32'hDEAD_BEEF);
        wait_ack();
        repeat (3) @(negedge clk_mem);

        check("sb_drained", sb.size(), 0);
        check("bus_conflicts", conflicts, 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
